// File: rtl/bx_dispatch_ctrl_pkg.sv
// Shared types and default sizes for the blockBX dispatch controller.
package bx_dispatch_ctrl_pkg;
  localparam int BX_DATA_W = 32;
  localparam int BX_DEPTH  = 4;
  localparam int BX_CNT_W  = 16;

  typedef enum logic [1:0] {BX_IDLE, BX_CREQ, BX_SEND} bx_disp_state_e;
  typedef enum logic {BX_DEST_Y, BX_DEST_Z} bx_dest_e;

  typedef struct packed {
    logic                 need_c;
    bx_dest_e             dest;
    logic [BX_DATA_W-1:0] data;
  } bx_disp_entry_t;
endpackage

// File: rtl/bx_dispatch_ctrl_if.sv
// Handshake bundle between blockBX dst port and the Y/Z/C source ports.
interface bx_dispatch_ctrl_if import bx_dispatch_ctrl_pkg::*; #(
  parameter int DATA_W = BX_DATA_W,
  parameter int CNT_W  = BX_CNT_W
) ();
  logic              in_vld, in_rdy, in_dest, in_need_c;
  logic [DATA_W-1:0] in_data;
  logic              y_vld, y_rdy, z_vld, z_rdy, c_req, c_ack;
  logic [DATA_W-1:0] y_data, z_data, c_data;
  logic [CNT_W-1:0]  y_cnt, z_cnt;

  modport slave (
    input  in_vld, in_data, in_dest, in_need_c, y_rdy, z_rdy, c_ack,
    output in_rdy, y_vld, y_data, z_vld, z_data, c_req, c_data, y_cnt, z_cnt
  );
  modport master (
    output in_vld, in_data, in_dest, in_need_c, y_rdy, z_rdy, c_ack,
    input  in_rdy, y_vld, y_data, z_vld, z_data, c_req, c_data, y_cnt, z_cnt
  );
endinterface

// File: rtl/bx_sync_fifo.sv
// In-order entry buffer; pointers carry one extra wrap bit to tell full from empty.
module bx_sync_fifo import bx_dispatch_ctrl_pkg::*; #(
  parameter int DEPTH = BX_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic           pop_i,
  input  bx_disp_entry_t data_i,
  output bx_disp_entry_t head_o,
  output logic           full_o,
  output logic           empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wptr_q, rptr_q;
  bx_disp_entry_t mem_q [DEPTH];

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Payload storage needs no reset: nothing reads it until a push lands.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/bx_dispatch_ctrl.sv
// blockBX scheduler: buffers input transactions and steers the FIFO head to Y or Z,
// optionally after a req/ack exchange with C.
module bx_dispatch_ctrl import bx_dispatch_ctrl_pkg::*; #(
  parameter int DEPTH = BX_DEPTH,
  parameter int CNT_W = BX_CNT_W
) (
  input logic         clk,
  input logic         rst_n,
  bx_dispatch_ctrl_if.slave bus
);
  bx_disp_state_e   state_q, state_d;
  bx_disp_entry_t   head, wr_entry;
  logic             full, empty, rdy_q, push, pop;
  logic             y_vld, z_vld, c_req;
  logic [CNT_W-1:0] y_cnt_q, z_cnt_q;

  // rdy_q keeps in_rdy low while in reset and for the edge that releases it.
  assign bus.in_rdy = rdy_q & ~full;
  assign push       = bus.in_vld & bus.in_rdy;
  assign pop        = (y_vld & bus.y_rdy) | (z_vld & bus.z_rdy);
  assign wr_entry   = '{need_c: bus.in_need_c, dest: bx_dest_e'(bus.in_dest), data: bus.in_data};

  bx_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_entry),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BX_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    y_vld   = 1'b0;
    z_vld   = 1'b0;
    c_req   = 1'b0;
    case (state_q)
      BX_IDLE: if (!empty) state_d = head.need_c ? BX_CREQ : BX_SEND;
      BX_CREQ: begin
        c_req = 1'b1;
        if (bus.c_ack) state_d = BX_SEND;
      end
      BX_SEND: begin
        y_vld = (head.dest == BX_DEST_Y);
        z_vld = (head.dest == BX_DEST_Z);
        if (pop) state_d = BX_IDLE;
      end
      default: state_d = BX_IDLE;
    endcase
  end

  // Payloads are forced to zero whenever their qualifier is low.
  assign bus.y_vld  = y_vld;
  assign bus.z_vld  = z_vld;
  assign bus.c_req  = c_req;
  assign bus.y_data = y_vld ? head.data : '0;
  assign bus.z_data = z_vld ? head.data : '0;
  assign bus.c_data = c_req ? head.data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt_q <= '0;
      z_cnt_q <= '0;
    end else begin
      if (y_vld && bus.y_rdy && y_cnt_q != '1) y_cnt_q <= y_cnt_q + CNT_W'(1);
      if (z_vld && bus.z_rdy && z_cnt_q != '1) z_cnt_q <= z_cnt_q + CNT_W'(1);
    end
  end

  assign bus.y_cnt = y_cnt_q;
  assign bus.z_cnt = z_cnt_q;
endmodule

// File: tb/tb_bx_dispatch_ctrl.sv
// Scoreboarded bench for bx_dispatch_ctrl; a second narrow-counter instance covers saturation.
module tb_bx_dispatch_ctrl;
  import bx_dispatch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bx_dispatch_ctrl_if bif ();
  bx_dispatch_ctrl_if #(.CNT_W(2)) sif ();

  bx_dispatch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  bx_dispatch_ctrl #(.CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

  typedef struct {
    logic        dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        stall_y = 1'b0, stall_z = 1'b0;
  logic [31:0] held_y = '0, held_z = '0;

  // Output monitor: exclusivity, stall stability and in-order delivery.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_y = 1'b0;
      stall_z = 1'b0;
    end else begin
      checks++;
      if (int'(bif.y_vld) + int'(bif.z_vld) + int'(bif.c_req) > 1) begin
        errors++;
        $display("FAIL onehot: y_vld=%0b z_vld=%0b c_req=%0b, want at most one high",
                 bif.y_vld, bif.z_vld, bif.c_req);
      end
      if (stall_y) begin
        checks++;
        if (bif.y_vld !== 1'b1 || bif.y_data !== held_y) begin
          errors++;
          $display("FAIL y_stall: vld=%0b data=%h, want vld=1 data=%h", bif.y_vld, bif.y_data, held_y);
        end
      end
      if (stall_z) begin
        checks++;
        if (bif.z_vld !== 1'b1 || bif.z_data !== held_z) begin
          errors++;
          $display("FAIL z_stall: vld=%0b data=%h, want vld=1 data=%h", bif.z_vld, bif.z_data, held_z);
        end
      end
      if (bif.y_vld && bif.y_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_y: got data=%h, want no transfer", bif.y_data);
        end else begin
          e = sb.pop_front();
          if (e.dest !== 1'b0 || e.data !== bif.y_data) begin
            errors++;
            $display("FAIL sb_y: got Y data=%h, want dest=%0b data=%h", bif.y_data, e.dest, e.data);
          end
        end
      end
      if (bif.z_vld && bif.z_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_z: got data=%h, want no transfer", bif.z_data);
        end else begin
          e = sb.pop_front();
          if (e.dest !== 1'b1 || e.data !== bif.z_data) begin
            errors++;
            $display("FAIL sb_z: got Z data=%h, want dest=%0b data=%h", bif.z_data, e.dest, e.data);
          end
        end
      end
      stall_y = bif.y_vld && !bif.y_rdy;
      stall_z = bif.z_vld && !bif.z_rdy;
      held_y  = bif.y_data;
      held_z  = bif.z_data;
    end
  end

  // Returns one cycle after the accepting edge (i.e. in cycle N+1).
  task automatic push(input logic [31:0] d, input logic dst, input logic nc);
    int   t;
    exp_t e;
    bif.in_vld = 1'b1; bif.in_data = d; bif.in_dest = dst; bif.in_need_c = nc;
    t = 0;
    while (bif.in_rdy !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL push_timeout: in_rdy=%0b, want 1 within 100 cycles", bif.in_rdy);
    end else begin
      e.dest = dst; e.data = d;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bif.in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bif.y_vld || bif.z_vld || bif.c_req) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    bif.in_vld = 1'b1; bif.in_data = 32'hDEAD_BEEF; bif.in_dest = 1'b0; bif.in_need_c = 1'b0;
    bif.y_rdy = 1'b1; bif.z_rdy = 1'b1; bif.c_ack = 1'b0;
    sif.in_vld = 1'b0; sif.in_data = '0; sif.in_dest = 1'b0; sif.in_need_c = 1'b0;
    sif.y_rdy = 1'b1; sif.z_rdy = 1'b1; sif.c_ack = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bif.in_rdy, bif.y_vld, bif.z_vld, bif.c_req} !== 4'b0 || bif.y_data !== '0 ||
        bif.z_data !== '0 || bif.c_data !== '0 || bif.y_cnt !== '0 || bif.z_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outs: rdy=%0b y=%0b z=%0b c=%0b yd=%h zd=%h cd=%h yc=%0d zc=%0d, want all 0",
               bif.in_rdy, bif.y_vld, bif.z_vld, bif.c_req, bif.y_data, bif.z_data, bif.c_data,
               bif.y_cnt, bif.z_cnt);
    end
    bif.in_vld = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bif.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_early: in_rdy=%0b, want 0", bif.in_rdy);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_rise: in_rdy=%0b, want 1", bif.in_rdy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bif.y_vld, bif.z_vld, bif.c_req} !== 3'b0) begin
      errors++;
      $display("FAIL reset_no_push: y=%0b z=%0b c=%0b, want 0 0 0", bif.y_vld, bif.z_vld, bif.c_req);
    end
  endtask

  task automatic test_single_y();
    push(32'hA5, 1'b0, 1'b0);
    checks++;
    if (bif.y_vld !== 1'b0) begin
      errors++;
      $display("FAIL y_lat_early: y_vld=%0b at N+1, want 0", bif.y_vld);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.y_vld !== 1'b1 || bif.y_data !== 32'hA5) begin
      errors++;
      $display("FAIL y_lat_n2: y_vld=%0b y_data=%h, want 1 a5", bif.y_vld, bif.y_data);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.y_cnt !== 16'd1 || bif.z_cnt !== 16'd0 || bif.y_vld !== 1'b0) begin
      errors++;
      $display("FAIL y_count: y_cnt=%0d z_cnt=%0d y_vld=%0b, want 1 0 0", bif.y_cnt, bif.z_cnt, bif.y_vld);
    end
  endtask

  task automatic test_creq_z();
    push(32'h11, 1'b1, 1'b1);
    checks++;
    if (bif.c_req !== 1'b0) begin
      errors++;
      $display("FAIL creq_early: c_req=%0b at N+1, want 0", bif.c_req);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.c_req !== 1'b1 || bif.c_data !== 32'h11 || bif.z_vld !== 1'b0) begin
      errors++;
      $display("FAIL creq_n2: c_req=%0b c_data=%h z_vld=%0b, want 1 11 0", bif.c_req, bif.c_data, bif.z_vld);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.c_req !== 1'b1) begin
      errors++;
      $display("FAIL creq_hold: c_req=%0b while waiting for ack, want 1", bif.c_req);
    end
    bif.c_ack = 1'b1;
    @(posedge clk); #1;
    bif.c_ack = 1'b0;
    checks++;
    if (bif.c_req !== 1'b0 || bif.z_vld !== 1'b1 || bif.z_data !== 32'h11 || bif.c_data !== '0) begin
      errors++;
      $display("FAIL creq_after_ack: c_req=%0b z_vld=%0b z_data=%h c_data=%h, want 0 1 11 0",
               bif.c_req, bif.z_vld, bif.z_data, bif.c_data);
    end
    wait_drain();
    checks++;
    if (bif.z_cnt !== 16'd1) begin
      errors++;
      $display("FAIL z_count1: z_cnt=%0d, want 1", bif.z_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bif.z_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(i), 1'b1, 1'b0);
    checks++;
    if (bif.in_rdy !== 1'b0 || bif.z_vld !== 1'b1 || bif.z_data !== 32'h40) begin
      errors++;
      $display("FAIL full_stall: in_rdy=%0b z_vld=%0b z_data=%h, want 0 1 40", bif.in_rdy, bif.z_vld, bif.z_data);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: in_rdy=%0b, want 0", bif.in_rdy);
    end
    bif.z_rdy = 1'b1;
    push(32'h44, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (bif.z_cnt !== 16'd6) begin
      errors++;
      $display("FAIL z_count6: z_cnt=%0d, want 6", bif.z_cnt);
    end
  endtask

  task automatic test_stray_ack();
    bif.c_ack = 1'b1;
    @(posedge clk); #1;
    bif.c_ack = 1'b0;
    checks++;
    if ({bif.y_vld, bif.z_vld, bif.c_req} !== 3'b0) begin
      errors++;
      $display("FAIL ack_idle: y=%0b z=%0b c=%0b, want 0 0 0", bif.y_vld, bif.z_vld, bif.c_req);
    end
    bif.y_rdy = 1'b0;
    push(32'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    bif.c_ack = 1'b1;
    @(posedge clk); #1;
    bif.c_ack = 1'b0;
    checks++;
    if (bif.y_vld !== 1'b1 || bif.y_data !== 32'h22 || bif.c_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_send: y_vld=%0b y_data=%h c_req=%0b, want 1 22 0", bif.y_vld, bif.y_data, bif.c_req);
    end
    bif.y_rdy = 1'b1;
    wait_drain();
    push(32'h33, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (bif.c_req !== 1'b1 || bif.c_data !== 32'h33) begin
      errors++;
      $display("FAIL ack_first_creq: c_req=%0b c_data=%h, want 1 33", bif.c_req, bif.c_data);
    end
    bif.c_ack = 1'b1;
    @(posedge clk); #1;
    bif.c_ack = 1'b0;
    checks++;
    if (bif.c_req !== 1'b0 || bif.y_vld !== 1'b1 || bif.y_data !== 32'h33) begin
      errors++;
      $display("FAIL ack_fast_send: c_req=%0b y_vld=%0b y_data=%h, want 0 1 33", bif.c_req, bif.y_vld, bif.y_data);
    end
    wait_drain();
    checks++;
    if (bif.y_cnt !== 16'd3) begin
      errors++;
      $display("FAIL y_count3: y_cnt=%0d, want 3", bif.y_cnt);
    end
  endtask

  // Narrow 2-bit counters saturate at 3; five Y sends must leave it there.
  task automatic test_saturation();
    int t;
    for (int i = 0; i < 5; i++) begin
      sif.in_vld = 1'b1; sif.in_data = 32'h70 + 32'(i); sif.in_dest = 1'b0; sif.in_need_c = 1'b0;
      t = 0;
      while (sif.in_rdy !== 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      sif.in_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (i == 0 || i == 2 || i == 4) begin
        checks++;
        if (sif.y_cnt !== ((i == 0) ? 2'd1 : 2'd3)) begin
          errors++;
          $display("FAIL sat_cnt[%0d]: y_cnt=%0d, want %0d", i, sif.y_cnt, (i == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic seen;
    bif.y_rdy = 1'b0;
    push(32'h55, 1'b0, 1'b0);
    push(32'h66, 1'b0, 1'b0);
    checks++;
    if (bif.y_vld !== 1'b1 || bif.y_data !== 32'h55) begin
      errors++;
      $display("FAIL pre_reset_send: y_vld=%0b y_data=%h, want 1 55", bif.y_vld, bif.y_data);
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bif.y_vld !== 1'b0 || bif.y_data !== '0 || bif.in_rdy !== 1'b0 || bif.y_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_send: y_vld=%0b y_data=%h in_rdy=%0b y_cnt=%0d, want 0 0 0 0",
               bif.y_vld, bif.y_data, bif.in_rdy, bif.y_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bif.y_rdy = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bif.y_vld || bif.z_vld || bif.c_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bif.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: output seen=%0b in_rdy=%0b, want 0 1", seen, bif.in_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single_y();
    test_creq_z();
    test_back_to_back();
    test_stray_ack();
    test_saturation();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
